// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store unit: access size, sequencer state and bus lane count.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } lsu_state_t;

    localparam int BE_W = 4;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication and misalign detection on the request side,
// load lane extraction and sign/zero extension on the response side.
module lsu_align
    import lsu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  mem_size_t         req_size_i,
    input  logic [1:0]        req_addr_lo_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic [BE_W-1:0]   be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              misalign_o,
    input  mem_size_t         rsp_size_i,
    input  logic [1:0]        rsp_addr_lo_i,
    input  logic              rsp_zext_i,
    input  logic [DATA_W-1:0] rsp_rdata_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        be_o       = '0;
        wdata_o    = '0;
        misalign_o = 1'b0;
        case (req_size_i)
            BYTE: begin
                be_o    = 4'b0001 << req_addr_lo_i;
                wdata_o = {4{req_wdata_i[7:0]}};
            end
            HALF_WORD: begin
                be_o       = 4'b0011 << req_addr_lo_i;
                wdata_o    = {2{req_wdata_i[15:0]}};
                misalign_o = req_addr_lo_i[0];
            end
            WORD: begin
                be_o       = 4'b1111;
                wdata_o    = req_wdata_i;
                misalign_o = |req_addr_lo_i;
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before trimming and extending.
    assign shifted = rsp_rdata_i >> {rsp_addr_lo_i, 3'b000};

    always_comb begin
        ld_data_o = shifted;
        case (rsp_size_i)
            BYTE:      ld_data_o = rsp_zext_i ? {24'b0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            HALF_WORD: ld_data_o = rsp_zext_i ? {16'b0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            default:   ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer running one data-memory access per instruction on a req/gnt/rvalid bus.
// Define LSU_TIMEOUT_EN to bound the bus wait and retire a stuck access with a timeout_o pulse.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_req_i,
    input  logic              ex_wr_en_i,
    input  mem_size_t         ex_size_i,
    input  logic              ex_zero_extend_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    output logic              stall_o,
    output logic              ld_valid_o,
    output logic [DATA_W-1:0] ld_data_o,
    output logic              misalign_o,
    output logic              timeout_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    lsu_state_t        state_q, state_d;
    logic              we_q, zext_q;
    mem_size_t         size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q, req_be;
    logic [DATA_W-1:0] wdata_q, ld_data_q, req_wdata, rsp_data;
    logic              req_misalign, accept, timeout_fire, timed_out_q;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .req_size_i    (ex_size_i),
        .req_addr_lo_i (ex_addr_i[1:0]),
        .req_wdata_i   (ex_wdata_i),
        .be_o          (req_be),
        .wdata_o       (req_wdata),
        .misalign_o    (req_misalign),
        .rsp_size_i    (size_q),
        .rsp_addr_lo_i (addr_q[1:0]),
        .rsp_zext_i    (zext_q),
        .rsp_rdata_i   (mem_rdata_i),
        .ld_data_o     (rsp_data)
    );

    assign accept = (state_q == IDLE) && ex_req_i && !req_misalign;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             waiting;

    // A completing handshake in the last allowed cycle wins over the timeout.
    assign waiting      = (state_q == REQ && !mem_gnt_i) || (state_q == RESP && !mem_rvalid_i);
    assign timeout_fire = waiting && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (accept)
                cnt_q <= '0;
            else if (state_q == REQ || state_q == RESP)
                cnt_q <= cnt_q + 1'b1;
            timed_out_q <= timeout_fire;
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign timed_out_q  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (mem_gnt_i) state_d = we_q ? DONE : RESP;
                     else if (timeout_fire) state_d = DONE;
                     else state_d = REQ;
            RESP:    if (mem_rvalid_i || timeout_fire) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        ld_valid_o = 1'b0;
        timeout_o  = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_be_o   = '0;
        case (state_q)
            IDLE: begin
                stall_o    = accept;
                misalign_o = ex_req_i && req_misalign;
            end
            REQ: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
                mem_we_o  = we_q;
                mem_be_o  = be_q;
            end
            RESP: stall_o = 1'b1;
            DONE: begin
                ld_valid_o = !we_q && !timed_out_q;
                timeout_o  = timed_out_q;
            end
            default: ;
        endcase
    end

    // Request fields are frozen at acceptance so the bus sees them stable until gnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q      <= 1'b0;
            zext_q    <= 1'b0;
            size_q    <= BYTE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            ld_data_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= ex_wr_en_i;
                zext_q  <= ex_zero_extend_i;
                size_q  <= ex_size_i;
                addr_q  <= ex_addr_i;
                be_q    <= req_be;
                wdata_q <= req_wdata;
            end
            if (state_q == RESP && mem_rvalid_i)
                ld_data_q <= rsp_data;
        end
    end

    assign mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata_o = wdata_q;
    assign ld_data_o   = ld_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl: stores, loads, misalignment, bus wait states and async reset.
// The timeout scenario is compiled in only when LSU_TIMEOUT_EN is defined.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_req, ex_wr_en, ex_zext;
    mem_size_t   ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic        stall, ld_valid, misalign, timeout;
    logic [31:0] ld_data;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int fails  = 0;

    lsu_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .ex_req_i         (ex_req),
        .ex_wr_en_i       (ex_wr_en),
        .ex_size_i        (ex_size),
        .ex_zero_extend_i (ex_zext),
        .ex_addr_i        (ex_addr),
        .ex_wdata_i       (ex_wdata),
        .stall_o          (stall),
        .ld_valid_o       (ld_valid),
        .ld_data_o        (ld_data),
        .misalign_o       (misalign),
        .timeout_o        (timeout),
        .mem_req_o        (mem_req),
        .mem_we_o         (mem_we),
        .mem_addr_o       (mem_addr),
        .mem_be_o         (mem_be),
        .mem_wdata_o      (mem_wdata),
        .mem_gnt_i        (mem_gnt),
        .mem_rvalid_i     (mem_rvalid),
        .mem_rdata_i      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Store with gnt in the first REQ cycle; observes a 4-cycle window ending back in IDLE.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input mem_size_t sz,
                            output logic [3:0] be, output logic [31:0] bwd, output logic [31:0] badr,
                            output int stalls, output int reqs, output int valids);
        stalls = 0; reqs = 0; valids = 0; be = '0; bwd = '0; badr = '0;
        ex_req = 1'b1; ex_wr_en = 1'b1; ex_size = sz; ex_zext = 1'b0; ex_addr = addr; ex_wdata = wd;
        for (int c = 0; c < 4; c++) begin
            mem_gnt = (c == 1);
            #1;
            if (stall) stalls++;
            if (ld_valid) valids++;
            if (mem_req) begin
                reqs++;
                be = mem_be; bwd = mem_wdata; badr = mem_addr;
                if (!mem_we) be = 4'hx;
            end
            tick();
            ex_req = 1'b0;
        end
        mem_gnt = 1'b0;
    endtask

    // Load with gnt in the first REQ cycle and rvalid one cycle later; 5-cycle window.
    task automatic do_load(input logic [31:0] addr, input mem_size_t sz, input logic zx,
                           input logic [31:0] rdata, output logic [31:0] data,
                           output int stalls, output int valids);
        stalls = 0; valids = 0; data = '0;
        ex_req = 1'b1; ex_wr_en = 1'b0; ex_size = sz; ex_zext = zx; ex_addr = addr; ex_wdata = '0;
        mem_rdata = rdata;
        for (int c = 0; c < 5; c++) begin
            mem_gnt    = (c == 1);
            mem_rvalid = (c == 2);
            #1;
            if (stall) stalls++;
            if (ld_valid) begin
                valids++;
                data = ld_data;
            end
            tick();
            ex_req = 1'b0;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_req = 1'b0; ex_wr_en = 1'b0; ex_size = BYTE; ex_zext = 1'b0;
        ex_addr = '0; ex_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req: got %b expected 0", mem_req); end
        checks++; if (ld_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_ld_valid: got %b expected 0", ld_valid); end
        checks++; if (ld_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_ld_data: got %h expected 0", ld_data); end
        checks++; if (mem_be !== 4'h0) begin fails++; $display("[TB] FAIL reset_be: got %h expected 0", mem_be); end
        checks++; if (mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr); end
        checks++; if (timeout !== 1'b0) begin fails++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stores();
        logic [3:0]  be;
        logic [31:0] bwd, badr;
        int stalls, reqs, valids;
        do_store(32'h100, 32'hDEADBEEF, WORD, be, bwd, badr, stalls, reqs, valids);
        checks++; if (be !== 4'b1111) begin fails++; $display("[TB] FAIL sw_be: got %b expected 1111", be); end
        checks++; if (badr !== 32'h100) begin fails++; $display("[TB] FAIL sw_addr: got %h expected 100", badr); end
        checks++; if (bwd !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL sw_wdata: got %h expected deadbeef", bwd); end
        checks++; if (stalls !== 2) begin fails++; $display("[TB] FAIL sw_stall_cycles: got %0d expected 2", stalls); end
        checks++; if (reqs !== 1 || valids !== 0) begin fails++; $display("[TB] FAIL sw_req_valid: got req %0d valid %0d expected 1 0", reqs, valids); end
        do_store(32'h103, 32'h123456A5, BYTE, be, bwd, badr, stalls, reqs, valids);
        checks++; if (be !== 4'b1000) begin fails++; $display("[TB] FAIL sb_be: got %b expected 1000", be); end
        checks++; if (bwd !== 32'hA5A5A5A5) begin fails++; $display("[TB] FAIL sb_wdata: got %h expected a5a5a5a5", bwd); end
        checks++; if (badr !== 32'h100) begin fails++; $display("[TB] FAIL sb_addr: got %h expected 100", badr); end
        do_store(32'h102, 32'hABCD1234, HALF_WORD, be, bwd, badr, stalls, reqs, valids);
        checks++; if (be !== 4'b1100) begin fails++; $display("[TB] FAIL sh_be: got %b expected 1100", be); end
        checks++; if (bwd !== 32'h12341234) begin fails++; $display("[TB] FAIL sh_wdata: got %h expected 12341234", bwd); end
    endtask

    task automatic test_loads();
        logic [31:0] d;
        int stalls, valids;
        do_load(32'h101, BYTE, 1'b0, 32'h000080FF, d, stalls, valids);
        checks++; if (d !== 32'hFFFFFF80) begin fails++; $display("[TB] FAIL lb_data: got %h expected ffffff80", d); end
        checks++; if (stalls !== 3) begin fails++; $display("[TB] FAIL lb_stall_cycles: got %0d expected 3", stalls); end
        checks++; if (valids !== 1) begin fails++; $display("[TB] FAIL lb_valid_pulses: got %0d expected 1", valids); end
        do_load(32'h101, BYTE, 1'b1, 32'h000080FF, d, stalls, valids);
        checks++; if (d !== 32'h00000080) begin fails++; $display("[TB] FAIL lbu_data: got %h expected 00000080", d); end
        do_load(32'h102, HALF_WORD, 1'b1, 32'hBEEF0000, d, stalls, valids);
        checks++; if (d !== 32'h0000BEEF) begin fails++; $display("[TB] FAIL lhu_data: got %h expected 0000beef", d); end
        do_load(32'h102, HALF_WORD, 1'b0, 32'hBEEF0000, d, stalls, valids);
        checks++; if (d !== 32'hFFFFBEEF) begin fails++; $display("[TB] FAIL lh_data: got %h expected ffffbeef", d); end
        do_load(32'h100, WORD, 1'b0, 32'h13579BDF, d, stalls, valids);
        checks++; if (d !== 32'h13579BDF) begin fails++; $display("[TB] FAIL lw_data: got %h expected 13579bdf", d); end
        checks++; if (ld_data !== 32'h13579BDF) begin fails++; $display("[TB] FAIL ld_data_hold: got %h expected 13579bdf", ld_data); end
    endtask

    task automatic test_misalign();
        int reqs;
        logic [31:0] addrs [2] = '{32'h102, 32'h101};
        mem_size_t   sizes [2] = '{WORD, HALF_WORD};
        for (int i = 0; i < 2; i++) begin
            reqs = 0;
            ex_req = 1'b1; ex_wr_en = 1'b0; ex_size = sizes[i]; ex_addr = addrs[i]; mem_gnt = 1'b1;
            #1;
            checks++; if (misalign !== 1'b1) begin fails++; $display("[TB] FAIL misalign_flag_%0d: got %b expected 1", i, misalign); end
            checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL misalign_stall_%0d: got %b expected 0", i, stall); end
            for (int c = 0; c < 3; c++) begin
                if (mem_req) reqs++;
                tick();
                #1;
            end
            checks++; if (reqs !== 0) begin fails++; $display("[TB] FAIL misalign_req_%0d: got %0d cycles expected 0", i, reqs); end
            ex_req = 1'b0; mem_gnt = 1'b0;
            tick();
        end
    endtask

    // gnt withheld 5 cycles, rvalid 3 cycles after gnt; ex_req stays high through DONE as a stalled pipe would.
    task automatic test_wait_states();
        int stalls = 0, valids = 0, stable = 0;
        logic [31:0] d = '0;
        ex_req = 1'b1; ex_wr_en = 1'b0; ex_size = WORD; ex_zext = 1'b0; ex_addr = 32'h200;
        mem_rdata = 32'hCAFEF00D;
        for (int c = 0; c < 14; c++) begin
            mem_gnt    = (c == 6);
            mem_rvalid = (c == 9);
            ex_req     = (c <= 10);
            #1;
            if (stall) stalls++;
            if (ld_valid) begin valids++; d = ld_data; end
            if (mem_req && mem_addr == 32'h200 && mem_be == 4'hF && !mem_we) stable++;
            tick();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; ex_req = 1'b0;
        checks++; if (stalls !== 10) begin fails++; $display("[TB] FAIL wait_stall_cycles: got %0d expected 10", stalls); end
        checks++; if (valids !== 1) begin fails++; $display("[TB] FAIL wait_valid_pulses: got %0d expected 1", valids); end
        checks++; if (stable !== 6) begin fails++; $display("[TB] FAIL wait_req_stable: got %0d cycles expected 6", stable); end
        checks++; if (d !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL wait_data: got %h expected cafef00d", d); end
    endtask

    task automatic test_stale_rvalid();
        int valids = 0;
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h11111111;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (ld_valid || mem_req) valids++;
            tick();
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        checks++; if (valids !== 0) begin fails++; $display("[TB] FAIL idle_rvalid_ignored: got %0d events expected 0", valids); end
        checks++; if (ld_data !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL idle_rvalid_data: got %h expected cafef00d", ld_data); end
    endtask

    task automatic test_reset_mid_access();
        int events = 0;
        ex_req = 1'b1; ex_wr_en = 1'b0; ex_size = WORD; ex_zext = 1'b0; ex_addr = 32'h300;
        mem_rdata = 32'h87654321;
        tick();
        ex_req = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("[TB] FAIL resp_stall: got %b expected 1", stall); end
        reset = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("[TB] FAIL rst_drop: got stall %b req %b expected 0 0", stall, mem_req); end
        checks++; if (ld_data !== 32'h0) begin fails++; $display("[TB] FAIL rst_ld_data: got %h expected 0", ld_data); end
        mem_rvalid = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (ld_valid || stall || mem_req) events++;
            tick();
        end
        mem_rvalid = 1'b0;
        checks++; if (events !== 0) begin fails++; $display("[TB] FAIL rst_rvalid_ignored: got %0d events expected 0", events); end
        checks++; if (ld_data !== 32'h0) begin fails++; $display("[TB] FAIL rst_rvalid_data: got %h expected 0", ld_data); end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int at = -1, pulses = 0, reqs = 0, valids = 0;
        ex_req = 1'b1; ex_wr_en = 1'b0; ex_size = WORD; ex_addr = 32'h400;
        for (int c = 0; c < 270; c++) begin
            #1;
            if (timeout) begin pulses++; at = c; end
            if (mem_req) reqs++;
            if (ld_valid) valids++;
            tick();
            ex_req = 1'b0;
        end
        checks++; if (pulses !== 1 || at !== 256) begin fails++; $display("[TB] FAIL timeout_pulse: got %0d at %0d expected 1 at 256", pulses, at); end
        checks++; if (reqs !== 255 || valids !== 0) begin fails++; $display("[TB] FAIL timeout_req_valid: got req %0d valid %0d expected 255 0", reqs, valids); end
    endtask
`endif

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_misalign();
        test_wait_states();
        test_stale_rvalid();
        test_reset_mid_access();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
